// File: rtl/div_iter.sv
// Radix-2 restoring divider, one quotient bit per clock, with signed/unsigned operands.
// Divide-by-zero and signed overflow finish from IDLE without entering the iteration loop.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             div_start_i,
    input  logic             div_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             div_done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic [4:0]       rd_addr_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor_mag;
    logic             quo_neg;
    logic             rem_neg;
    logic [4:0]       rd_tag;

    logic             accept;
    logic             div_zero;
    logic             overflow;
    logic             calc_last;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    assign accept    = (state == IDLE) && div_start_i && !kill_i;
    assign div_zero  = (divisor_i == '0);
    assign overflow  = div_signed_i && (dividend_i == MIN_NEG) && (divisor_i == '1);
    assign calc_last = (counter == CW'(WIDTH - 1));

    assign dividend_mag = (div_signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign divisor_abs  = (div_signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // The shifted partial remainder needs one extra bit; the trial's MSB is its borrow.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor_mag};

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !div_zero && !overflow) state_next = CALC;
            CALC: begin
                if (kill_i)         state_next = IDLE;
                else if (calc_last) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            counter     <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor_mag <= '0;
            quo_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            rd_tag      <= '0;
            div_done_o  <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            rd_addr_o   <= '0;
        end else begin
            div_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            quotient_o  <= '1;
                            remainder_o <= dividend_i;
                            rd_addr_o   <= rd_addr_i;
                            div_done_o  <= 1'b1;
                        end else if (overflow) begin
                            quotient_o  <= MIN_NEG;
                            remainder_o <= '0;
                            rd_addr_o   <= rd_addr_i;
                            div_done_o  <= 1'b1;
                        end else begin
                            counter     <= '0;
                            rem         <= '0;
                            quo         <= dividend_mag;
                            divisor_mag <= divisor_abs;
                            quo_neg     <= div_signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                            rem_neg     <= div_signed_i & dividend_i[WIDTH-1];
                            rd_tag      <= rd_addr_i;
                        end
                    end
                end
                CALC: begin
                    if (!kill_i) begin
                        rem     <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                        quo     <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                        counter <= counter + 1'b1;
                    end
                end
                FIX: begin
                    if (!kill_i) begin
                        quotient_o  <= quo_neg ? -quo : quo;
                        remainder_o <= rem_neg ? -rem : rem;
                        rd_addr_o   <= rd_tag;
                        div_done_o  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, randomized ops against an
// arithmetic reference, and hand-written kill / back-to-back / reset sequences.
module tb_div_iter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [4:0]       rd_addr;
    logic             kill;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [4:0]       rd_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .div_start_i  (start),
        .div_signed_i (div_signed),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .rd_addr_i    (rd_addr),
        .kill_i       (kill),
        .busy_o       (busy),
        .div_done_o   (done),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .rd_addr_o    (rd_out)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: RISC-V DIV/DIVU/REM/REMU semantics from plain integer arithmetic.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic drive_start(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag);
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        rd_addr    = tag;
        start      = 1'b1;
    endtask

    // Issues one op (cycle 0 = now) and waits up to 40 cycles for its done pulse.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] q, output logic [31:0] r,
                          output logic [4:0] t, output int lat, output int busy_cnt);
        drive_start(sgn, a, b, tag);
        lat = -1;
        busy_cnt = 0;
        q = '0;
        r = '0;
        t = '0;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                q = quotient;
                r = remainder;
                t = rd_out;
                check("busy_at_done", {63'd0, busy}, 64'd0);
                break;
            end
            tick;
        end
        if (lat > 0) begin
            tick;
            check("done_single_cycle", {63'd0, done}, 64'd0);
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] q, r, eq, er, a, b, q_prev;
        logic [4:0]  t;
        logic        sgn;
        int          lat, bcnt, exp_lat, dcnt;

        rst = 1'b1;
        start = 1'b0;
        kill = 1'b0;
        div_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        rd_addr = '0;
        tick;
        tick;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_quotient", {32'd0, quotient}, 64'd0);
        check("rst_remainder", {32'd0, remainder}, 64'd0);
        check("rst_rd_addr", {59'd0, rd_out}, 64'd0);
        rst = 1'b0;
        tick;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          5'd3,  32'd14,         32'd2,          34};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          5'd9,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
        vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'h7FFF_FFFC,  32'd1,          34};
        vecs[3] = '{1'b1, 32'h1234,       32'd0,          5'd11, 32'hFFFF_FFFF,  32'h1234,       1};
        vecs[4] = '{1'b0, 32'h1234,       32'd0,          5'd12, 32'hFFFF_FFFF,  32'h1234,       1};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  32'd0,          1};
        vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          32'h8000_0000,  34};
        vecs[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  5'd15, 32'hFFFF_FFFD,  32'd1,          34};
        vecs[8] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  5'd16, 32'd3,          32'hFFFF_FFFF,  34};
        vecs[9] = '{1'b0, 32'd5,          32'hFFFF_FFFF,  5'd31, 32'd0,          32'd5,          34};

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag, q, r, t, lat, bcnt);
            check($sformatf("vec%0d_q", i), {32'd0, q}, {32'd0, vecs[i].exp_q});
            check($sformatf("vec%0d_r", i), {32'd0, r}, {32'd0, vecs[i].exp_r});
            check($sformatf("vec%0d_tag", i), {59'd0, t}, {59'd0, vecs[i].tag});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt),
                  64'((vecs[i].exp_lat == 1) ? 0 : 33));
        end

        for (int i = 0; i < 150; i++) begin
            sgn = 1'($urandom_range(1));
            a = $urandom;
            case ($urandom_range(5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(15);
                default: b = $urandom >> $urandom_range(31);
            endcase
            if ($urandom_range(7) == 0) a = 32'h8000_0000;
            ref_div(sgn, a, b, eq, er);
            exp_lat = (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
            run_op(sgn, a, b, 5'(i), q, r, t, lat, bcnt);
            check($sformatf("rnd%0d_q(s=%0d a=%0h b=%0h)", i, sgn, a, b), {32'd0, q}, {32'd0, eq});
            check($sformatf("rnd%0d_r(s=%0d a=%0h b=%0h)", i, sgn, a, b), {32'd0, r}, {32'd0, er});
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat));
        end

        // Kill mid-CALC with an ignored second start, then a fresh op after the flush.
        q_prev = quotient;
        dcnt = 0;
        drive_start(1'b0, 32'd50, 32'd5, 5'd1);
        for (int c = 1; c <= 46; c++) begin
            tick;
            start = 1'b0;
            kill = 1'b0;
            if (c == 5)  drive_start(1'b0, 32'd9, 32'd3, 5'd8);
            if (c == 10) kill = 1'b1;
            if (c == 12) drive_start(1'b0, 32'd9, 32'd3, 5'd2);
            if (c == 11) begin
                check("kill_busy_low", {63'd0, busy}, 64'd0);
                check("kill_q_held", {32'd0, quotient}, {32'd0, q_prev});
            end
            if (c < 46 && done) dcnt++;
            if (c == 46) begin
                check("kill_restart_done", {63'd0, done}, 64'd1);
                check("kill_restart_q", {32'd0, quotient}, 64'd3);
                check("kill_restart_r", {32'd0, remainder}, 64'd0);
                check("kill_restart_tag", {59'd0, rd_out}, 64'd2);
            end
        end
        check("kill_no_spurious_done", 64'(dcnt), 64'd0);
        tick;

        // Kill in the FIX cycle: no done, results held.
        dcnt = 0;
        drive_start(1'b0, 32'd100, 32'd7, 5'd5);
        for (int c = 1; c <= 36; c++) begin
            tick;
            start = 1'b0;
            kill = (c == 33);
            if (done) dcnt++;
        end
        kill = 1'b0;
        check("killfix_no_done", 64'(dcnt), 64'd0);
        check("killfix_busy", {63'd0, busy}, 64'd0);
        check("killfix_q_held", {32'd0, quotient}, 64'd3);
        check("killfix_tag_held", {59'd0, rd_out}, 64'd2);

        // Kill alongside a start in IDLE drops the start.
        dcnt = 0;
        drive_start(1'b0, 32'd0, 32'd0, 5'd7);
        kill = 1'b1;
        tick;
        start = 1'b0;
        kill = 1'b0;
        check("killidle_busy", {63'd0, busy}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            if (done) dcnt++;
            tick;
        end
        check("killidle_no_done", 64'(dcnt), 64'd0);
        check("killidle_r_held", {32'd0, remainder}, 64'd0);

        // Back-to-back ops, then reset in cycle 15 of a third op.
        drive_start(1'b0, 32'd20, 32'd6, 5'd4);
        for (int c = 1; c <= 83; c++) begin
            tick;
            start = 1'b0;
            if (c == 34) begin
                check("b2b_first_done", {63'd0, done}, 64'd1);
                check("b2b_first_q", {32'd0, quotient}, 64'd3);
                check("b2b_first_r", {32'd0, remainder}, 64'd2);
                drive_start(1'b0, 32'd21, 32'd5, 5'd6);
            end
            if (c == 35) check("b2b_gap_done", {63'd0, done}, 64'd0);
            if (c == 68) begin
                check("b2b_second_done", {63'd0, done}, 64'd1);
                check("b2b_second_q", {32'd0, quotient}, 64'd4);
                check("b2b_second_r", {32'd0, remainder}, 64'd1);
                check("b2b_second_tag", {59'd0, rd_out}, 64'd6);
                drive_start(1'b0, 32'd7, 32'd1, 5'd7);
            end
        end
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_q", {32'd0, quotient}, 64'd0);
        check("midrst_r", {32'd0, remainder}, 64'd0);
        check("midrst_tag", {59'd0, rd_out}, 64'd0);
        tick;
        rst = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (done || busy) dcnt++;
        end
        check("midrst_no_done", 64'(dcnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
Multi-cycle radix-2 restoring divider for the milano EX stage. It supports signed and unsigned 32-bit operands.
It sits directly under the mul/div unit: that unit issues one divide per start pulse and consumes quotient, remainder and the rd tag when the done pulse arrives.
It handles the RISC-V divide-by-zero and signed-overflow corner cases internally, so the consumer only selects which result it needs.

Parameters:
WIDTH, 32, operand/result width in bits (the iteration count equals WIDTH).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset, asynchronous, active-high.
div_start_i  in  1  request a divide; accepted only in IDLE.
div_signed_i  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU; sampled with start.
dividend_i  in  WIDTH  dividend; sampled with start.
divisor_i  in  WIDTH  divisor; sampled with start.
rd_addr_i  in  5  destination tag; sampled with start.
kill_i  in  1  flush; aborts any operation in flight.
busy_o  out  1  high whenever state != IDLE.
div_done_o  out  1  one-cycle result-valid pulse.
quotient_o  out  WIDTH  final quotient; held until the next done.
remainder_o  out  WIDTH  final remainder; held until the next done.
rd_addr_o  out  5  tag of the completed operation; held with the results.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, busy_o=0, div_done_o=0, quotient_o=0, remainder_o=0, rd_addr_o=0, counter=0.
- Reset asserted mid-operation aborts immediately; no done pulse is ever issued for the aborted operation.
- States: IDLE, CALC, FIX.
- Cycle numbering: cycle 0 is the IDLE cycle in which div_start_i=1 and kill_i=0.
- IDLE, on accept:
  - Latch div_signed_i and rd_addr_i.
  - Latch |dividend| and |divisor|: two's-complement magnitude when signed and the MSB is set, raw value otherwise.
  - Record the quotient sign: signed & (a[MSB] ^ b[MSB]).
  - Record the remainder sign: signed & a[MSB].
- Divide by zero (divisor_i=0), special case:
  - Stay in IDLE.
  - Register quotient_o = all ones and remainder_o = dividend_i unmodified.
  - div_done_o is high in cycle 1.
- Signed overflow (signed, dividend = 1<<(WIDTH-1), divisor = all ones), special case:
  - Stay in IDLE.
  - Register quotient_o = 1<<(WIDTH-1) and remainder_o = 0.
  - div_done_o is high in cycle 1.
- Otherwise, go to CALC with counter=0, partial remainder = 0, and the working quotient register = |dividend|.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - |divisor|, computed at WIDTH+1 bits.
  - If the trial is non-negative: rem = trial and the quotient LSB = 1; else keep rem and the LSB = 0.
  - counter++. After WIDTH iterations (cycles 1..WIDTH), go to FIX.
- FIX (cycle WIDTH+1):
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register both results and rd_addr_o, pulse div_done_o, and return to IDLE.
  - div_done_o is high in cycle WIDTH+2, i.e. cycle 34 for the default WIDTH.
- A new start is accepted in the same cycle div_done_o is high, because state is already IDLE then.
- div_start_i while busy_o=1 is ignored: no queueing, no effect on the operation in flight.
- kill_i has priority over everything except reset:
  - In CALC or FIX: next state is IDLE and no done pulse is issued.
  - In IDLE, a simultaneous start is dropped.
  - Result and tag outputs keep their previous values.
- div_done_o is never high for two consecutive cycles.
- busy_o is low in the cycle div_done_o is high.

Test Plan:
- Unsigned 100/7, rd=3 -> busy_o high in cycles 1..33; done in cycle 34 with q=14, r=2, rd_addr_o=3.
- Signed -7/2 (0xFFFFFFF9 / 0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF at cycle 34. Unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
- Divide by zero, dividend 0x1234, signed and unsigned -> done in cycle 1 with q=0xFFFFFFFF, r=0x1234, busy_o never high.
- Signed 0x80000000 / 0xFFFFFFFF -> done in cycle 1 with q=0x80000000, r=0.
- Start 50/5; second start 9/3 in cycle 5; kill in cycle 10 -> no done pulse, busy_o low from cycle 11. A new start 9/3 in cycle 12 -> done 34 cycles later with q=3, r=0.
- Back-to-back: 20/6 then 21/5 issued in the done cycle of the first -> two done pulses 34 cycles apart with (3,2) and (4,1). Reset in cycle 15 of a third operation -> all outputs 0 immediately, no done.
